div_sequencer: RTL and testbench
================================

DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; the iteration count equals XLEN.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request a divide; accepted only when ready=1.
REQ-005 Port: kill  input  1  pipeline flush; aborts any operation in progress.
REQ-006 Port: op  input  2  00=DIV signed quotient, 01=DIVU, 10=REM signed remainder, 11=REMU.
REQ-007 Port: dividend  input  XLEN  numerator, sampled on acceptance only.
REQ-008 Port: divisor  input  XLEN  denominator, sampled on acceptance only.
REQ-009 Port: ready  output  1  high in IDLE; start is accepted this cycle.
REQ-010 Port: busy  output  1  high from the cycle after acceptance until the cycle before done.
REQ-011 Port: stall  output  1  equals busy OR (start AND ready AND NOT kill); holds the pipeline.
REQ-012 Port: done  output  1  single-cycle pulse; result valid.
REQ-013 Port: quotient  output  XLEN  registered quotient of the last completed operation.
REQ-014 Port: remainder  output  XLEN  registered remainder of the last completed operation.
REQ-015 Port: result  output  XLEN  quotient for op[1]=0, remainder for op[1]=1, using the op latched at acceptance.

Function
REQ-016 States: IDLE, RUN, FIX, DONE. The sequencer SHALL not use any other states.
REQ-017 IDLE + start + no kill: latch op, dividend, and divisor; compute magnitudes (signed ops negate negative operands in two's complement); go to RUN with iteration counter = XLEN-1.
REQ-018 RUN: one restoring shift-subtract step per cycle, MSB first; partial remainder XLEN+1 bits wide so the subtract sign bit decides; counter decrements; at 0 go to FIX.
REQ-019 FIX: negate quotient if signed op and operand signs differ; negate remainder if signed op and dividend negative; register outputs; go to DONE.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; normal latency is start in cycle 0, done in cycle XLEN+2 (34).
REQ-021 Divisor zero: skip RUN/FIX; quotient = all ones, remainder = dividend; done in cycle 2 (IDLE->DONE).
REQ-022 Signed overflow (op signed, dividend = 1 followed by zeros, divisor = all ones): quotient = dividend, remainder = 0; done in cycle 2.
REQ-023 Divisor-zero check SHALL take priority over the overflow check.
REQ-024 start while not IDLE SHALL be ignored; latched operands SHALL be unaffected by input changes after acceptance.
REQ-025 kill in any state: next state IDLE, no done, quotient/remainder/result unchanged.
REQ-026 kill and start in the same IDLE cycle: kill wins; the request is not accepted.
REQ-027 quotient/remainder/result SHALL hold their values until the next completed operation.

Reset
REQ-028 reset SHALL take priority over kill and start, forcing IDLE on the next edge.
REQ-029 While reset is high: ready=0, busy=0, stall=0, done=0, quotient=0, remainder=0, result=0, counter=0.
REQ-030 Reset asserted mid-RUN: abort with no done; outputs cleared.

Structure
REQ-031 Shared package div_pkg SHALL hold the op encoding constants (DIV, DIVU, REM, REMU) and the state enum (IDLE, RUN, FIX, DONE).
REQ-032 One combinational sub-module div_step SHALL implement a single restoring iteration (inputs: partial remainder, quotient, divisor magnitude; outputs: next partial remainder, next quotient); the sequencer owns all registers.

Verification
REQ-033 DIV 100/7 with start in cycle 0: done in cycle 34, quotient=14, remainder=2, result=14; busy high in cycles 1..33.
REQ-034 DIV -7/2 and REM -7/2: quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; DIVU 0xFFFFFFFF/2: quotient=0x7FFFFFFF, remainder=1.
REQ-035 DIV 5/0: done in cycle 2, quotient=0xFFFFFFFF, remainder=5; DIV 0x80000000/0xFFFFFFFF: done in cycle 2, quotient=0x80000000, remainder=0.
REQ-036 kill in cycle 10 of a DIVU: no done pulse, ready=1 in cycle 11, previous result held; a new REMU 9/4 started then yields result=1 after 34 cycles.
REQ-037 reset in cycle 15 of RUN: all outputs 0 next cycle, no done pulse; start with kill in the same cycle is not accepted and stall=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: op encodings, sequencer states
// and a helper that tells signed ops apart from unsigned ones.
package div_pkg;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    function automatic logic isSignedOp(input logic [1:0] opCode);
        return (opCode == DIV) || (opCode == REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration, purely combinational.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   partRem_i,
    input  logic [XLEN-1:0] quot_i,
    input  logic [XLEN-1:0] divisorMag_i,
    output logic [XLEN:0]   partRem_o,
    output logic [XLEN-1:0] quot_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic            fits;

    // The sign bit of the trial subtraction decides whether to restore.
    always_comb begin
        shifted   = {partRem_i, quot_i[XLEN-1]};
        diff      = shifted - {2'b00, divisorMag_i};
        fits      = ~diff[XLEN+1];
        partRem_o = fits ? diff[XLEN:0] : shifted[XLEN:0];
        quot_o    = {quot_i[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider sequencer: magnitudes in, XLEN restoring
// steps, sign fix-up, one-cycle done pulse. Divide-by-zero and overflow bypass the loop.
module div_sequencer
    import div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            ready,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              negDividend_q, negDividend_d;
    logic              negDivisor_q, negDivisor_d;
    logic              holdDone_q, holdDone_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic [XLEN-1:0]   quotient_q, quotient_d;
    logic [XLEN-1:0]   remainder_q, remainder_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [XLEN:0]     stepRem;
    logic [XLEN-1:0]   stepQuot;
    logic              signedIn;
    logic              signedLatched;
    logic [XLEN-1:0]   quotFix;
    logic [XLEN-1:0]   remFix;

    div_step #(.XLEN(XLEN)) u_step (
        .partRem_i   (rem_q),
        .quot_i      (quot_q),
        .divisorMag_i(dvsr_q),
        .partRem_o   (stepRem),
        .quot_o      (stepQuot)
    );

    // Special cases park their raw results in quot_q/rem_q and spend one
    // DONE cycle with holdDone set before the done pulse.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        negDividend_d = negDividend_q;
        negDivisor_d  = negDivisor_q;
        holdDone_d    = holdDone_q;
        rem_d         = rem_q;
        quot_d        = quot_q;
        dvsr_d        = dvsr_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        result_d      = result_q;
        signedIn      = isSignedOp(op);
        signedLatched = isSignedOp(op_q);
        quotFix       = (signedLatched && (negDividend_q ^ negDivisor_q)) ? ('0 - quot_q) : quot_q;
        remFix        = (signedLatched && negDividend_q) ? ('0 - rem_q[XLEN-1:0]) : rem_q[XLEN-1:0];

        case (state_q)
            IDLE: begin
                if (start && !kill) begin
                    op_d          = op;
                    negDividend_d = dividend[XLEN-1];
                    negDivisor_d  = divisor[XLEN-1];
                    if (divisor == '0) begin
                        quot_d     = '1;
                        rem_d      = {1'b0, dividend};
                        holdDone_d = 1'b1;
                        state_d    = DONE;
                    end else if (signedIn && (dividend == MOST_NEG) && (divisor == '1)) begin
                        quot_d     = dividend;
                        rem_d      = '0;
                        holdDone_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        quot_d  = (signedIn && dividend[XLEN-1]) ? ('0 - dividend) : dividend;
                        dvsr_d  = (signedIn && divisor[XLEN-1]) ? ('0 - divisor) : divisor;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(XLEN - 1);
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                quot_d = stepQuot;
                rem_d  = stepRem;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                quotient_d  = quotFix;
                remainder_d = remFix;
                result_d    = op_q[1] ? remFix : quotFix;
                state_d     = DONE;
            end
            DONE: begin
                if (holdDone_q) begin
                    quotient_d  = quot_q;
                    remainder_d = rem_q[XLEN-1:0];
                    result_d    = op_q[1] ? rem_q[XLEN-1:0] : quot_q;
                    holdDone_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (kill) begin
            state_d     = IDLE;
            holdDone_d  = 1'b0;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            result_d    = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            negDividend_q <= 1'b0;
            negDivisor_q  <= 1'b0;
            holdDone_q    <= 1'b0;
            rem_q         <= '0;
            quot_q        <= '0;
            dvsr_q        <= '0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            result_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            negDividend_q <= negDividend_d;
            negDivisor_q  <= negDivisor_d;
            holdDone_q    <= holdDone_d;
            rem_q         <= rem_d;
            quot_q        <= quot_d;
            dvsr_q        <= dvsr_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            result_q      <= result_d;
        end
    end

    // Handshake outputs are forced low while reset is held.
    always_comb begin
        ready = (state_q == IDLE) && !reset;
        busy  = ((state_q == RUN) || (state_q == FIX) || ((state_q == DONE) && holdDone_q)) && !reset;
        done  = (state_q == DONE) && !holdDone_q && !kill && !reset;
        stall = busy || (start && ready && !kill);
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign result    = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer with hand-computed results.
module tb_div_sequencer;
    import div_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            kill;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            ready;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic [XLEN-1:0] result;

    int assertCount = 0;
    int failCount   = 0;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .kill     (kill),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .quotient (quotient),
        .remainder(remainder),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Starts one operation in the next cycle, scrambles inputs while it runs
    // and checks latency, busy span and results at the done pulse.
    task automatic applyStimulus(input string tag, input logic [1:0] opv, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expQ,
                                 input logic [31:0] expR, input int expLat);
        int  lat;
        int  busyCycles;
        logic seen;
        nextCycle();
        op = opv; dividend = a; divisor = b; start = 1'b1; kill = 1'b0;
        #1;
        checkOutput({tag, "_ready0"}, ready, 1);
        checkOutput({tag, "_stall0"}, stall, 1);
        lat = 0; busyCycles = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            nextCycle();
            lat++;
            dividend = $urandom; divisor = $urandom; op = 2'($urandom_range(3, 0));
            #1;
            if (done) seen = 1'b1;
            else if (busy) busyCycles++;
        end
        checkOutput({tag, "_doneSeen"}, seen, 1);
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_busySpan"}, busyCycles, expLat - 1);
        checkOutput({tag, "_busyAtDone"}, busy, 0);
        checkOutput({tag, "_quot"}, quotient, expQ);
        checkOutput({tag, "_rem"}, remainder, expR);
        checkOutput({tag, "_result"}, result, opv[1] ? expR : expQ);
        nextCycle();
        start = 1'b0;
        #1;
        checkOutput({tag, "_readyAfter"}, ready, 1);
        checkOutput({tag, "_donePulse"}, done, 0);
    endtask

    initial begin
        logic doneSeen;
        reset = 1'b1; start = 1'b0; kill = 1'b0; op = DIV; dividend = '0; divisor = '0;
        nextCycle();
        nextCycle();
        start = 1'b1;
        #1;
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_stall", stall, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_quot", quotient, 0);
        checkOutput("rst_rem", remainder, 0);
        checkOutput("rst_result", result, 0);
        nextCycle();
        reset = 1'b0; start = 1'b0;
        #1;
        checkOutput("rst_readyAfter", ready, 1);

        applyStimulus("div100by7", DIV, 32'd100, 32'd7, 32'd14, 32'd2, 34);
        applyStimulus("divNeg7by2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        applyStimulus("remNeg7by2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
        applyStimulus("div7byNeg2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34);
        applyStimulus("divuMaxBy2", DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 34);
        applyStimulus("divuMinByMax", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 34);
        applyStimulus("div5by0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 2);
        applyStimulus("overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2);
        applyStimulus("remOverflow", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 2);
        applyStimulus("zeroPriority", DIV, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 2);

        // Kill in cycle 10 of a DIVU: previous results must survive.
        nextCycle();
        op = DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1; kill = 1'b0;
        #1;
        doneSeen = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            start = 1'b0;
            if (c == 10) kill = 1'b1;
            #1;
            if (done) doneSeen = 1'b1;
        end
        nextCycle();
        kill = 1'b0;
        #1;
        checkOutput("kill_noDone", doneSeen, 0);
        checkOutput("kill_ready", ready, 1);
        checkOutput("kill_busy", busy, 0);
        checkOutput("kill_quotHeld", quotient, 32'hFFFF_FFFF);
        checkOutput("kill_remHeld", remainder, 32'h8000_0000);
        checkOutput("kill_resultHeld", result, 32'hFFFF_FFFF);
        applyStimulus("remu9by4", REMU, 32'd9, 32'd4, 32'd2, 32'd1, 34);

        // Reset in cycle 15 of RUN, then a start that is killed.
        nextCycle();
        op = DIV; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        #1;
        doneSeen = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            nextCycle();
            start = 1'b0;
            if (c == 15) reset = 1'b1;
            #1;
            if (done) doneSeen = 1'b1;
        end
        checkOutput("midRst_busy", busy, 0);
        checkOutput("midRst_ready", ready, 0);
        nextCycle();
        reset = 1'b0; start = 1'b1; kill = 1'b1;
        #1;
        checkOutput("midRst_noDone", doneSeen | done, 0);
        checkOutput("midRst_quot", quotient, 0);
        checkOutput("midRst_rem", remainder, 0);
        checkOutput("midRst_result", result, 0);
        checkOutput("startKill_stall", stall, 0);
        checkOutput("startKill_ready", ready, 1);
        nextCycle();
        start = 1'b0; kill = 1'b0;
        #1;
        checkOutput("startKill_notAccepted", ready, 1);
        checkOutput("startKill_busy", busy, 0);

        applyStimulus("remNeg100by7", REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
